// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter
// Shares the video RAM write port between the host bus and a built-in fill
// engine. Everything runs in the RAM write-clock domain and every output is
// a flop.
//
// Ports:
//   clk, rst_n                  write-side clock, async active-low reset
//   host_req/addr/data          host write request, held until host_ack
//   host_ack                    one-cycle pulse, host write issued this cycle
//   fill_start/base/count/data  fill command, sampled on fill_start
//   fill_busy, fill_done        fill in progress / completion pulse
//   vram_we/waddr/wdata         RAM write side
//
// Build option: define VRAM_FILL_INC_EN to make word k of a fill equal
// fill_data+k (test patterns). When it is undefined, every fill write uses
// the constant fill_data and no incrementer is built.
//
// Fill FSM:
//   state | meaning
//   IDLE  | no fill active; fill_start is accepted
//   RUN   | fill competing for the port; fill_start is ignored
module vram_write_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [DWIDTH-1:0] host_data,
  output logic              host_ack,
  input  logic              fill_start,
  input  logic [AWIDTH-1:0] fill_base,
  input  logic [AWIDTH:0]   fill_count,
  input  logic [DWIDTH-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              vram_we,
  output logic [AWIDTH-1:0] vram_waddr,
  output logic [DWIDTH-1:0] vram_wdata
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  // The pointer records the requester granted most recently.
  localparam logic [0:0] PTR_HOST = 1'b0;
  localparam logic [0:0] PTR_FILL = 1'b1;

  localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
  localparam logic [AWIDTH:0]   REM_ONE  = (AWIDTH + 1)'(1);
`ifdef VRAM_FILL_INC_EN
  localparam logic [DWIDTH-1:0] WORD_ONE = DWIDTH'(1);
`endif

  logic [0:0]        state_q, state_d;
  logic [0:0]        ptr_q, ptr_d;
  logic [AWIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [AWIDTH:0]   fill_rem_q, fill_rem_d;
  logic [DWIDTH-1:0] fill_word_q, fill_word_d;
  logic              vram_we_q, vram_we_d;
  logic [AWIDTH-1:0] vram_waddr_q, vram_waddr_d;
  logic [DWIDTH-1:0] vram_wdata_q, vram_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_done_q, fill_done_d;

  logic host_elig, fill_elig, grant_host, grant_fill;

  always_comb begin
    // While ack is out the held request has already been served.
    host_elig  = host_req & ~host_ack_q;
    fill_elig  = (state_q == ST_RUN);
    grant_host = host_elig & (~fill_elig | (ptr_q == PTR_FILL));
    grant_fill = fill_elig & (~host_elig | (ptr_q == PTR_HOST));

    state_d      = state_q;
    ptr_d        = ptr_q;
    fill_addr_d  = fill_addr_q;
    fill_rem_d   = fill_rem_q;
    fill_word_d  = fill_word_q;
    vram_we_d    = 1'b0;
    vram_waddr_d = vram_waddr_q;
    vram_wdata_d = vram_wdata_q;
    host_ack_d   = 1'b0;
    fill_done_d  = 1'b0;

    if (grant_host) begin
      vram_we_d    = 1'b1;
      vram_waddr_d = host_addr;
      vram_wdata_d = host_data;
      host_ack_d   = 1'b1;
      ptr_d        = PTR_HOST;
    end

    if (grant_fill) begin
      vram_we_d    = 1'b1;
      vram_waddr_d = fill_addr_q;
      vram_wdata_d = fill_word_q;
      ptr_d        = PTR_FILL;
      fill_addr_d  = fill_addr_q + ADDR_ONE;   // wraps naturally
      fill_rem_d   = fill_rem_q - REM_ONE;
`ifdef VRAM_FILL_INC_EN
      fill_word_d  = fill_word_q + WORD_ONE;
`endif
      if (fill_rem_q == REM_ONE) begin
        state_d     = ST_IDLE;
        fill_done_d = 1'b1;
      end
    end

    if ((state_q == ST_IDLE) && fill_start) begin
      if (fill_count == '0) begin
        fill_done_d = 1'b1;
      end else begin
        state_d     = ST_RUN;
        fill_addr_d = fill_base;
        fill_rem_d  = fill_count;
        fill_word_d = fill_data;
      end
    end

    // Busy follows the next state so it drops together with the last write.
    fill_busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PTR_HOST;
      fill_addr_q  <= '0;
      fill_rem_q   <= '0;
      fill_word_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_waddr_q <= '0;
      vram_wdata_q <= '0;
      host_ack_q   <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fill_addr_q  <= fill_addr_d;
      fill_rem_q   <= fill_rem_d;
      fill_word_q  <= fill_word_d;
      vram_we_q    <= vram_we_d;
      vram_waddr_q <= vram_waddr_d;
      vram_wdata_q <= vram_wdata_d;
      host_ack_q   <= host_ack_d;
      fill_busy_q  <= fill_busy_d;
      fill_done_q  <= fill_done_d;
    end
  end

  assign vram_we    = vram_we_q;
  assign vram_waddr = vram_waddr_q;
  assign vram_wdata = vram_wdata_q;
  assign host_ack   = host_ack_q;
  assign fill_busy  = fill_busy_q;
  assign fill_done  = fill_done_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
module tb_vram_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_ack;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_count;
  logic [DW-1:0] fill_data;
  logic          fill_busy;
  logic          fill_done;
  logic          vram_we;
  logic [AW-1:0] vram_waddr;
  logic [DW-1:0] vram_wdata;

  vram_write_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_ack(host_ack),
    .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
    .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done),
    .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A fill is a queue of pending (addr, data) writes; the fill is active
  // while the queue is non-empty.
  logic          exp_we, exp_ack, exp_busy, exp_done;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic [AW-1:0] fq_addr[$];
  logic [DW-1:0] fq_data[$];
  bit            m_last_host;

  initial begin
    bit h_el, f_el, was_idle, win_h, win_f;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_we = 0; exp_ack = 0; exp_busy = 0; exp_done = 0;
        exp_waddr = '0; exp_wdata = '0;
        fq_addr.delete(); fq_data.delete();
        m_last_host = 1'b1;
      end else begin
        h_el     = host_req && !exp_ack;
        f_el     = fq_addr.size() != 0;
        was_idle = !f_el;
        if (h_el && f_el) begin
          win_h = !m_last_host;
          win_f = m_last_host;
        end else begin
          win_h = h_el;
          win_f = f_el;
        end
        exp_we = 0; exp_ack = 0; exp_done = 0;
        if (win_h) begin
          exp_we = 1; exp_ack = 1;
          exp_waddr = host_addr; exp_wdata = host_data;
          m_last_host = 1'b1;
        end
        if (win_f) begin
          exp_we = 1;
          exp_waddr = fq_addr.pop_front();
          exp_wdata = fq_data.pop_front();
          m_last_host = 1'b0;
          if (fq_addr.size() == 0) exp_done = 1;
        end
        if (was_idle && fill_start) begin
          if (fill_count == '0) exp_done = 1;
          for (int k = 0; k < int'(fill_count); k++) begin
            fq_addr.push_back(AW'(int'(fill_base) + k));
`ifdef VRAM_FILL_INC_EN
            fq_data.push_back(DW'(int'(fill_data) + k));
`else
            fq_data.push_back(fill_data);
`endif
          end
        end
        exp_busy = fq_addr.size() != 0;
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int fill_wr_cnt = 0;
  int host_wr_cnt = 0;
  int b2b_host    = 0;
  initial begin
    bit prev_host;
    prev_host = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("we",    32'(vram_we),    32'(exp_we));
        chk("ack",   32'(host_ack),   32'(exp_ack));
        chk("busy",  32'(fill_busy),  32'(exp_busy));
        chk("done",  32'(fill_done),  32'(exp_done));
        chk("waddr", 32'(vram_waddr), 32'(exp_waddr));
        chk("wdata", 32'(vram_wdata), 32'(exp_wdata));
        if (vram_we && !host_ack) fill_wr_cnt++;
        if (host_ack) begin
          host_wr_cnt++;
          if (prev_host) b2b_host++;
        end
        prev_host = host_ack;
      end else begin
        prev_host = 0;
      end
    end
  end

  // ---------------- host agent ----------------
  // 0: directed driving, 1: always re-request, 2: random, 3: drain
  int host_mode = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (host_mode == 1) begin
        if (!host_req || host_ack) begin
          host_req  = 1'b1;
          host_addr = AW'($urandom);
          host_data = DW'($urandom);
        end
      end else if (host_mode == 2) begin
        if (!host_req || host_ack) begin
          host_req  = ($urandom_range(0, 2) != 0);
          host_addr = AW'($urandom);
          host_data = DW'($urandom);
        end
      end else if (host_mode == 3) begin
        if (!host_req || host_ack) host_req = 1'b0;
      end
    end
  end

  task automatic drain_host();
    int t;
    host_mode = 3;
    t = 0;
    while (host_req && t < 20) begin @(negedge clk); t++; end
    chk("host_drain_timeout", 32'(host_req), 32'd0);
    host_mode = 0;
  endtask

  task automatic start_fill(input logic [AW-1:0] b, input logic [AW:0] c, input logic [DW-1:0] d);
    fill_start = 1'b1; fill_base = b; fill_count = c; fill_data = d;
    @(negedge clk);
    fill_start = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int snap_f, snap_h, t;
    logic [AW-1:0] exp_a[4];
    logic [DW-1:0] seq[3];
    host_req = 0; host_addr = '0; host_data = '0;
    fill_start = 0; fill_base = '0; fill_count = '0; fill_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(vram_we),    32'd0);
    chk("rst_ack",   32'(host_ack),   32'd0);
    chk("rst_busy",  32'(fill_busy),  32'd0);
    chk("rst_done",  32'(fill_done),  32'd0);
    chk("rst_waddr", 32'(vram_waddr), 32'd0);
    chk("rst_wdata", 32'(vram_wdata), 32'd0);
    rst_n = 1'b1;

    // single host write, request held through the ack cycle
    @(negedge clk);
    host_req = 1; host_addr = 8'h10; host_data = 16'h1234;
    @(negedge clk);
    chk("t1_we",    32'(vram_we),    32'd1);
    chk("t1_waddr", 32'(vram_waddr), 32'h10);
    chk("t1_wdata", 32'(vram_wdata), 32'h1234);
    chk("t1_ack",   32'(host_ack),   32'd1);
    @(negedge clk);
    chk("t1_no_double_we",  32'(vram_we),  32'd0);
    chk("t1_no_double_ack", 32'(host_ack), 32'd0);
    host_req = 0;
    @(negedge clk);

    // wrapping fill of four words
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    start_fill(8'hFE, 9'd4, 16'hAAAA);
    chk("t2_busy_first", 32'(fill_busy), 32'd1);
    chk("t2_we_first",   32'(vram_we),   32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_we",    32'(vram_we),    32'd1);
      chk("t2_waddr", 32'(vram_waddr), 32'(exp_a[i]));
      chk("t2_wdata", 32'(vram_wdata), 32'hAAAA);
      chk("t2_done",  32'(fill_done),  (i == 3) ? 32'd1 : 32'd0);
      chk("t2_busy",  32'(fill_busy),  (i == 3) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    chk("t2_we_after", 32'(vram_we), 32'd0);

    // zero-length fill
    start_fill(8'h33, 9'd0, 16'h5555);
    chk("t4_done", 32'(fill_done), 32'd1);
    chk("t4_we",   32'(vram_we),   32'd0);
    chk("t4_busy", 32'(fill_busy), 32'd0);
    @(negedge clk);
    chk("t4_done_pulse", 32'(fill_done), 32'd0);
    chk("t4_busy_after", 32'(fill_busy), 32'd0);

`ifdef VRAM_FILL_INC_EN
    seq[0] = 16'hFFFF; seq[1] = 16'h0000; seq[2] = 16'h0001;
    start_fill(8'h00, 9'd3, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_wdata", 32'(vram_wdata), 32'(seq[i]));
    end
    repeat (2) @(negedge clk);
`else
    seq[0] = '0; seq[1] = '0; seq[2] = '0;
`endif

    // fill of six words against a continuously requesting host
    snap_f = fill_wr_cnt; snap_h = host_wr_cnt;
    host_mode = 1;
    start_fill(8'h40, 9'd6, 16'h0F0F);
    t = 0;
    while (!fill_done && t < 40) begin @(negedge clk); t++; end
    chk("t3_done_timeout", 32'(fill_done), 32'd1);
    drain_host();
    chk("t3_fill_writes", 32'(fill_wr_cnt - snap_f), 32'd6);
    chk("t3_host_writes_ge6", 32'(host_wr_cnt - snap_h >= 6), 32'd1);
    chk("t3_no_b2b_host", 32'(b2b_host), 32'd0);

    // full-range fill aborted by reset at the 100th write
    @(negedge clk);
    snap_f = fill_wr_cnt;
    start_fill(8'h00, 9'd256, 16'hC0DE);
    t = 0;
    while ((fill_wr_cnt - snap_f) < 100 && t < 300) begin @(negedge clk); t++; end
    chk("t5_reach_100", 32'(fill_wr_cnt - snap_f), 32'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_we",   32'(vram_we),   32'd0);
    chk("t5_rst_busy", 32'(fill_busy), 32'd0);
    chk("t5_rst_done", 32'(fill_done), 32'd0);
    chk("t5_rst_addr", 32'(vram_waddr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_done_after", 32'(fill_done), 32'd0);
    chk("t5_idle_after",    32'(fill_busy), 32'd0);
    host_req = 1; host_addr = 8'h05; host_data = 16'hBEEF;
    @(negedge clk);
    chk("t5_host_we",    32'(vram_we),    32'd1);
    chk("t5_host_waddr", 32'(vram_waddr), 32'h05);
    chk("t5_host_ack",   32'(host_ack),   32'd1);
    host_req = 0;
    repeat (2) @(negedge clk);

    // random traffic; fill_start also lands mid-fill and on fill_done
    host_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if (fill_done || $urandom_range(0, 29) == 0) begin
        fill_start = 1'b1;
        fill_base  = AW'($urandom);
        fill_count = ($urandom_range(0, 9) == 0) ? (AW+1)'($urandom_range(0, 256))
                                                 : (AW+1)'($urandom_range(0, 12));
        fill_data  = DW'($urandom);
      end else begin
        fill_start = 1'b0;
      end
      @(negedge clk);
    end
    fill_start = 1'b0;
    drain_host();
    t = 0;
    while (fill_busy && t < 600) begin @(negedge clk); t++; end
    chk("rand_fill_finish", 32'(fill_busy), 32'd0);
    chk("rand_no_b2b_host", 32'(b2b_host), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
